// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - walks the capture RAM from a start address and streams samples to the UART byte interface
module capture_readout #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    RAM_LATENCY = 1,
    parameter bit                    HEADER_EN   = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HEADER      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] count,
    input  logic                  abort,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [1:0]            WAIT_LAST = 2'(RAM_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [1:0]            wait_cnt;

    // Every control output is a pure decode of the registered state, so reset
    // and abort clear them on the very next edge with no extra bookkeeping.
    assign ram_en   = (state == S_READ);
    assign ram_addr = addr;
    assign tx_valid = (state == S_HDR) || (state == S_SEND);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            tx_data   <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state <= S_IDLE;
            // A byte handshaken in the abort cycle still counts as delivered.
            if ((state == S_SEND) && tx_ready) begin
                addr      <= addr + ONE;
                remaining <= remaining - ONE;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= start_addr;
                        remaining <= count;
                        if (HEADER_EN) begin
                            tx_data <= HEADER;
                            state   <= S_HDR;
                        end else if (count != '0) begin
                            state <= S_READ;
                        end else begin
                            state <= S_FIN;
                        end
                    end
                end
                S_HDR: begin
                    if (tx_ready) begin
                        state <= (remaining != '0) ? S_READ : S_FIN;
                    end
                end
                S_READ: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        tx_data <= ram_dout;
                        state   <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        addr      <= addr + ONE;
                        remaining <= remaining - ONE;
                        state     <= (remaining == ONE) ? S_FIN : S_READ;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - randomized and directed bench for capture_readout against a stream-level model
module tb_capture_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_v [2];
    logic        start_v [2];
    logic        abort_v [2];
    logic        ready_v [2];
    logic [15:0] sa_v    [2];
    logic [15:0] cnt_v   [2];

    logic        ram_en0, ram_en1, tx_valid0, tx_valid1, busy0, busy1, done0, done1;
    logic [15:0] ram_addr0;
    logic [3:0]  ram_addr1;
    logic [7:0]  dout0, dout1, txd0, txd1;

    // Instance 0: 16-bit addresses, 1-cycle RAM, header on.
    capture_readout #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RAM_LATENCY(1), .HEADER_EN(1'b1), .HEADER(8'hA5)) dut0 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .start_addr(sa_v[0]), .count(cnt_v[0]),
        .abort(abort_v[0]), .ram_en(ram_en0), .ram_addr(ram_addr0), .ram_dout(dout0),
        .tx_data(txd0), .tx_valid(tx_valid0), .tx_ready(ready_v[0]), .busy(busy0), .done(done0)
    );

    // Instance 1: 4-bit addresses, 2-cycle RAM, no header.
    capture_readout #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RAM_LATENCY(2), .HEADER_EN(1'b0), .HEADER(8'hA5)) dut1 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .start_addr(sa_v[1][3:0]), .count(cnt_v[1][3:0]),
        .abort(abort_v[1]), .ram_en(ram_en1), .ram_addr(ram_addr1), .ram_dout(dout1),
        .tx_data(txd1), .tx_valid(tx_valid1), .tx_ready(ready_v[1]), .busy(busy1), .done(done1)
    );

    logic [7:0] mem0 [65536];
    logic [7:0] mem1 [16];
    logic [7:0] p0, q1a, q1b;

    // Data outside a real read is random so a mistimed capture shows up.
    always @(posedge clk) begin
        p0  <= ram_en0 ? mem0[ram_addr0] : 8'($urandom);
        q1a <= ram_en1 ? mem1[ram_addr1] : 8'($urandom);
        q1b <= q1a;
    end
    assign dout0 = p0;
    assign dout1 = q1b;

    int checks = 0;
    int errors = 0;

    function automatic logic f_valid(input int i); return (i == 0) ? tx_valid0 : tx_valid1; endfunction
    function automatic logic f_en(input int i);    return (i == 0) ? ram_en0 : ram_en1; endfunction
    function automatic logic f_busy(input int i);  return (i == 0) ? busy0 : busy1; endfunction
    function automatic logic f_done(input int i);  return (i == 0) ? done0 : done1; endfunction
    function automatic logic [7:0] f_data(input int i); return (i == 0) ? txd0 : txd1; endfunction
    function automatic logic [15:0] f_addr(input int i); return (i == 0) ? ram_addr0 : {12'd0, ram_addr1}; endfunction
    function automatic logic [15:0] f_mask(input int i); return (i == 0) ? 16'hFFFF : 16'h000F; endfunction
    function automatic logic [7:0] mem_rd(input int i, input logic [15:0] a);
        return (i == 0) ? mem0[a] : mem1[a[3:0]];
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic bad(input string nm, input int i, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s inst%0d got %0h want none at %0t", nm, i, act, $time);
    endtask

    // Model: on an accepted start the whole expected byte and address stream is
    // computed up front; the monitor then consumes it handshake by handshake.
    bit         m_busy [2];
    bit         m_fin  [2];
    bit         m_zero [2];
    bit         hold   [2];
    bit         rd_pend[2];
    logic [7:0] hold_d [2];
    logic [7:0] exp_b  [2][64];
    logic [15:0] adr_b [2][64];
    int         exp_n [2], exp_h [2], adr_n [2], adr_h [2];
    logic [7:0] log_b  [2][64];
    logic [15:0] alog_b[2][64];
    int         log_n [2], alog_n [2], done_cnt [2];
    bit         mon_en = 1'b0;

    task automatic clear_model(input int i);
        exp_n[i] = 0; exp_h[i] = 0; adr_n[i] = 0; adr_h[i] = 0; rd_pend[i] = 1'b0;
    endtask

    task automatic mon(input int i);
        logic v, rdy, en, hs;
        logic [7:0] d;
        logic [15:0] a, ma;
        int n;
        v = f_valid(i); rdy = ready_v[i]; en = f_en(i); d = f_data(i); a = f_addr(i);
        hs = v && rdy;
        if (m_zero[i]) begin
            chk("rst_outputs", i, {28'd0, v, en, f_busy(i), f_done(i)}, 32'd0);
            chk("rst_tx_data", i, {24'd0, d}, 32'd0);
            chk("rst_ram_addr", i, {16'd0, a}, 32'd0);
            m_zero[i] = 1'b0;
        end
        chk("busy", i, {31'd0, f_busy(i)}, {31'd0, m_busy[i]});
        chk("done", i, {31'd0, f_done(i)}, {31'd0, m_fin[i]});
        chk("valid_and_en", i, {31'd0, v && en}, 32'd0);
        if (hold[i]) begin
            chk("hold_valid", i, {31'd0, v}, 32'd1);
            chk("hold_data", i, {24'd0, d}, {24'd0, hold_d[i]});
        end
        if (v) begin
            if (exp_h[i] < exp_n[i]) chk("byte", i, {24'd0, d}, {24'd0, exp_b[i][exp_h[i]]});
            else bad("unexpected_byte", i, {24'd0, d});
        end
        if (en) begin
            chk("one_outstanding", i, {31'd0, rd_pend[i]}, 32'd0);
            if (adr_h[i] < adr_n[i]) chk("ram_addr", i, {16'd0, a}, {16'd0, adr_b[i][adr_h[i]]});
            else bad("unexpected_read", i, {16'd0, a});
        end
        if (hs) begin
            if (log_n[i] < 64) begin log_b[i][log_n[i]] = d; log_n[i]++; end
            if (exp_h[i] < exp_n[i]) exp_h[i]++;
            rd_pend[i] = 1'b0;
        end
        if (en) begin
            if (alog_n[i] < 64) begin alog_b[i][alog_n[i]] = a; alog_n[i]++; end
            if (adr_h[i] < adr_n[i]) adr_h[i]++;
            rd_pend[i] = 1'b1;
        end
        if (f_done(i)) done_cnt[i]++;
        hold[i]   = v && !rdy && !abort_v[i] && !reset_v[i];
        hold_d[i] = d;
        if (reset_v[i]) begin
            m_busy[i] = 1'b0; m_fin[i] = 1'b0; m_zero[i] = 1'b1; hold[i] = 1'b0;
            clear_model(i);
        end else if (m_busy[i] && abort_v[i]) begin
            m_busy[i] = 1'b0; m_fin[i] = 1'b0;
            clear_model(i);
        end else if (m_fin[i]) begin
            m_fin[i] = 1'b0; m_busy[i] = 1'b0;
        end else if (m_busy[i]) begin
            if (hs && (exp_h[i] == exp_n[i])) m_fin[i] = 1'b1;
        end else if (start_v[i]) begin
            clear_model(i);
            m_busy[i] = 1'b1;
            ma = sa_v[i] & f_mask(i);
            n  = int'(cnt_v[i] & f_mask(i));
            if (i == 0) begin exp_b[i][0] = 8'hA5; exp_n[i] = 1; end
            for (int k = 0; k < n; k++) begin
                adr_b[i][adr_n[i]] = ma; adr_n[i]++;
                exp_b[i][exp_n[i]] = mem_rd(i, ma); exp_n[i]++;
                ma = (ma + 16'd1) & f_mask(i);
            end
            if (exp_n[i] == 0) m_fin[i] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    // rmode: 0 = always ready, 1 = random ready, 2 = stall 5 cycles on byte 0x7B
    task automatic run_dump(input int i, input logic [15:0] sa, input logic [15:0] cnt, input int rmode,
                            input int abort_at, input bit dup, output int cyc);
        int bp;
        bp = 0;
        log_n[i] = 0; alog_n[i] = 0; done_cnt[i] = 0;
        @(posedge clk); #1;
        sa_v[i] = sa; cnt_v[i] = cnt; start_v[i] = 1'b1; ready_v[i] = 1'b1;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        cyc = 0;
        while (f_busy(i) && (cyc < 3000)) begin
            if (rmode == 0) ready_v[i] = 1'b1;
            else if (rmode == 1) ready_v[i] = 1'($urandom_range(0, 1));
            else if (f_valid(i) && (f_data(i) == 8'h7B) && (bp < 5)) begin ready_v[i] = 1'b0; bp++; end
            else ready_v[i] = 1'b1;
            start_v[i] = dup && (cyc == 3);
            if (start_v[i]) begin sa_v[i] = 16'($urandom); cnt_v[i] = 16'($urandom); end
            abort_v[i] = (abort_at >= 0) && (log_n[i] == abort_at);
            @(posedge clk); #1;
            cyc++;
        end
        start_v[i] = 1'b0; abort_v[i] = 1'b0; ready_v[i] = 1'b1;
        chk("dump_timeout", i, {31'd0, f_busy(i)}, 32'd0);
    endtask

    logic [15:0] ev [8];
    int ev_n;

    task automatic check_bytes(input int i, input string nm);
        chk({nm, "_len"}, i, log_n[i], ev_n);
        for (int k = 0; k < ev_n && k < log_n[i]; k++) chk(nm, i, {24'd0, log_b[i][k]}, {16'd0, ev[k]});
    endtask

    task automatic check_addrs(input int i, input string nm);
        chk({nm, "_len"}, i, alog_n[i], ev_n);
        for (int k = 0; k < ev_n && k < alog_n[i]; k++) chk(nm, i, {16'd0, alog_b[i][k]}, {16'd0, ev[k]});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout inst0 got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, n, ab;
        logic [15:0] sa, cnt;
        for (int k = 0; k < 65536; k++) mem0[k] = 8'd0;
        for (int k = 0; k < 16; k++) mem1[k] = 8'd0;
        for (int i = 0; i < 2; i++) begin
            reset_v[i] = 1'b1; start_v[i] = 1'b0; abort_v[i] = 1'b0; ready_v[i] = 1'b1;
            sa_v[i] = 16'd0; cnt_v[i] = 16'd0;
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        reset_v[0] = 1'b0; reset_v[1] = 1'b0;

        // Basic dump
        mem0[0] = 8'h03; mem0[1] = 8'h01; mem0[2] = 8'h02; mem0[3] = 8'h07;
        run_dump(0, 16'd0, 16'd4, 0, -1, 1'b0, cyc);
        ev = '{16'hA5, 16'h03, 16'h01, 16'h02, 16'h07, 16'h0, 16'h0, 16'h0}; ev_n = 5;
        check_bytes(0, "basic_bytes");
        ev = '{16'd0, 16'd1, 16'd2, 16'd3, 16'h0, 16'h0, 16'h0, 16'h0}; ev_n = 4;
        check_addrs(0, "basic_addrs");
        chk("basic_done_cnt", 0, done_cnt[0], 1);
        chk("basic_cycles", 0, cyc, 14);

        // Backpressure on 0x7B
        mem0[16'h100] = 8'h11; mem0[16'h101] = 8'h7B; mem0[16'h102] = 8'h22;
        run_dump(0, 16'h100, 16'd3, 2, -1, 1'b0, cyc);
        ev = '{16'hA5, 16'h11, 16'h7B, 16'h22, 16'h0, 16'h0, 16'h0, 16'h0}; ev_n = 4;
        check_bytes(0, "bp_bytes");
        chk("bp_reads", 0, alog_n[0], 3);
        chk("bp_cycles", 0, cyc, 16);

        // Reset in SEND with tx_valid high
        log_n[0] = 0; alog_n[0] = 0;
        @(posedge clk); #1;
        sa_v[0] = 16'd0; cnt_v[0] = 16'd4; start_v[0] = 1'b1; ready_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        n = 0;
        while ((log_n[0] < 1) && (n < 50)) begin @(posedge clk); #1; n++; end
        ready_v[0] = 1'b0;
        while (!tx_valid0 && (n < 50)) begin @(posedge clk); #1; n++; end
        chk("rst_reach_send", 0, {31'd0, tx_valid0}, 32'd1);
        reset_v[0] = 1'b1;
        @(posedge clk); #1;
        reset_v[0] = 1'b0; ready_v[0] = 1'b1;
        chk("rst_busy", 0, {31'd0, busy0}, 32'd0);
        chk("rst_valid", 0, {31'd0, tx_valid0}, 32'd0);
        chk("rst_data", 0, {24'd0, txd0}, 32'd0);
        run_dump(0, 16'd0, 16'd4, 0, -1, 1'b0, cyc);
        ev = '{16'hA5, 16'h03, 16'h01, 16'h02, 16'h07, 16'h0, 16'h0, 16'h0}; ev_n = 5;
        check_bytes(0, "after_rst_bytes");

        // count = 0 with header
        run_dump(0, 16'd5, 16'd0, 0, -1, 1'b0, cyc);
        ev = '{16'hA5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; ev_n = 1;
        check_bytes(0, "cnt0_bytes");
        chk("cnt0_reads", 0, alog_n[0], 0);
        chk("cnt0_done", 0, done_cnt[0], 1);
        chk("cnt0_cycles", 0, cyc, 2);

        // Abort after two samples, then a full dump with a start collision
        for (int k = 0; k < 6; k++) mem0[16'h20 + k] = 8'(16 * (k + 1));
        run_dump(0, 16'h20, 16'd6, 0, 3, 1'b0, cyc);
        ev = '{16'hA5, 16'h10, 16'h20, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}; ev_n = 3;
        check_bytes(0, "abort_bytes");
        chk("abort_no_done", 0, done_cnt[0], 0);
        run_dump(0, 16'h20, 16'd6, 1, -1, 1'b1, cyc);
        ev = '{16'hA5, 16'h10, 16'h20, 16'h30, 16'h40, 16'h50, 16'h60, 16'h0}; ev_n = 7;
        check_bytes(0, "restart_bytes");
        chk("restart_done", 0, done_cnt[0], 1);

        // Instance 1: wrap-around and count = 0 without header
        mem1[14] = 8'hE1; mem1[15] = 8'hF2; mem1[0] = 8'h0A; mem1[1] = 8'h1B;
        run_dump(1, 16'd14, 16'd4, 0, -1, 1'b0, cyc);
        ev = '{16'd14, 16'd15, 16'd0, 16'd1, 16'h0, 16'h0, 16'h0, 16'h0}; ev_n = 4;
        check_addrs(1, "wrap_addrs");
        ev = '{16'hE1, 16'hF2, 16'h0A, 16'h1B, 16'h0, 16'h0, 16'h0, 16'h0}; ev_n = 4;
        check_bytes(1, "wrap_bytes");
        chk("wrap_cycles", 1, cyc, 17);
        run_dump(1, 16'd3, 16'd0, 0, -1, 1'b0, cyc);
        chk("nohdr_cnt0_bytes", 1, log_n[1], 0);
        chk("nohdr_cnt0_done", 1, done_cnt[1], 1);
        chk("nohdr_cnt0_cycles", 1, cyc, 1);

        // Randomized dumps on both instances
        for (int r = 0; r < 25; r++) begin
            sa  = ((r % 4) == 0) ? 16'hFFFC : 16'($urandom);
            cnt = 16'($urandom_range(0, 12));
            for (int k = 0; k < 12; k++) mem0[sa + 16'(k)] = 8'($urandom);
            ab = ((r % 5) == 4) ? int'($urandom_range(0, 1)) : -1;
            run_dump(0, sa, cnt, 1, ab, (r % 3) == 0, cyc);
            if (ab < 0) begin
                chk("rand0_len", 0, log_n[0], int'(cnt) + 1);
                chk("rand0_done", 0, done_cnt[0], 1);
            end
            for (int k = 0; k < 16; k++) mem1[k] = 8'($urandom);
            cnt = 16'($urandom_range(0, 15));
            run_dump(1, 16'($urandom_range(0, 15)), cnt, 1, -1, (r % 2) == 0, cyc);
            chk("rand1_len", 1, log_n[1], int'(cnt));
            chk("rand1_done", 1, done_cnt[1], 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Downstream stage of the logic-capture block: after a capture completes, walks the capture RAM from a start address and streams each stored 8-bit sample out over a valid/ready byte interface, which feeds the UART transmitter.
- Optionally prefixes the stream with a header byte so the host can frame the dump.
- Owns the RAM read port only; the capture block owns the write port.

Parameters:
ADDR_WIDTH, 16, width of capture RAM address and of the sample count
DATA_WIDTH, 8, sample width; equals tx_data width
RAM_LATENCY, 1, cycles from ram_en/ram_addr to valid ram_dout (1 or 2)
HEADER_EN, 1, 1 = send HEADER byte before samples; 0 = samples only
HEADER, 8'hA5, header byte value

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a dump; ignored while busy
start_addr  in  ADDR_WIDTH  first RAM address to read; sampled on accepted start
count  in  ADDR_WIDTH  number of samples to send; sampled on accepted start
abort  in  1  terminate dump; no done pulse
ram_en  out  1  RAM read enable
ram_addr  out  ADDR_WIDTH  RAM read address
ram_dout  in  DATA_WIDTH  RAM read data, valid RAM_LATENCY cycles after ram_en
tx_data  out  DATA_WIDTH  byte to transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse when last byte accepted

Behaviour:
- Reset (sync, reset=1 at a clk edge): state IDLE; ram_en=0, ram_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, internal address/remaining counters=0. Reset overrides start and abort in the same cycle.
- States: IDLE, HDR, READ, WAIT, SEND, FIN.
- IDLE: start=1 → latch addr=start_addr, remaining=count; busy=1 next cycle. Go to HDR if HEADER_EN, else READ if count!=0, else FIN.
- HDR: tx_data=HEADER, tx_valid=1. On handshake go to READ if remaining!=0, else FIN.
- READ: ram_en=1, ram_addr=addr for exactly one cycle. Go to WAIT.
- WAIT: hold RAM_LATENCY-1 extra cycles, then capture ram_dout into tx_data. Go to SEND.
- SEND: tx_valid=1.
  - tx_data and tx_valid stay stable while tx_ready=0.
  - On handshake: addr=addr+1 (mod 2^ADDR_WIDTH, wraps from all-ones to 0); remaining=remaining-1.
  - If remaining was 1, go to FIN; else go to READ.
- FIN: done=1 for one cycle, busy=0 next cycle, go to IDLE.
- Timing: start accepted at edge N → with HEADER_EN=1, tx_valid=1 with HEADER at edge N+1. With RAM_LATENCY=1 and tx_ready held 1, each sample costs 3 cycles: READ, WAIT, SEND.
- count=0: header only (HEADER_EN=1), or immediate done (HEADER_EN=0). No RAM read occurs.
- start while busy: ignored; latched values unchanged.
- abort=1 in any non-IDLE state:
  - next state IDLE; tx_valid=0, ram_en=0, busy=0; no done pulse.
  - If abort and a handshake coincide, the byte counts as delivered but the dump still ends without done.
- tx_valid never asserts outside HDR/SEND; ram_en never asserts outside READ.
- At most one RAM read is outstanding at a time.

Test Plan:
- Reset mid-dump: assert reset during SEND with tx_valid=1 → next edge all outputs 0, state IDLE; a following start works normally.
- Basic dump: RAM[0..3]={03,01,02,07}, start_addr=0, count=4, tx_ready=1, HEADER_EN=1 → bytes A5,03,01,02,07 in order; ram_addr sequence 0,1,2,3; single done pulse on the cycle after the 07 handshake.
- Backpressure: tx_ready=0 for 5 cycles during the byte 0x7B → tx_data stays 0x7B with tx_valid=1 throughout; no extra RAM reads; byte is sent exactly once.
- Wrap-around: ADDR_WIDTH=4, start_addr=14, count=4 → ram_addr sequence 14,15,0,1.
- count=0: HEADER_EN=1 gives only A5 then done; HEADER_EN=0 gives done 1 cycle after start with no tx_valid.
- Abort/start collisions: start during busy is ignored (stream unchanged). Abort after 2 samples → busy=0 next cycle, no done pulse; a new start then produces a full, correct stream.
